// File: rtl/twos_comp_to_signmag.sv
// Two's-complement to sign-magnitude converter; magnitude recovered LSB-first by copy-until-first-one-then-invert.
// Latency 1 cycle for non-negative words, WIDTH+1 for negative; one word in flight, result held until out_ready.
module twos_comp_to_signmag #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_min
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             found_q, found_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             min_q, min_d;

    logic accept;
    logic last_bit;
    logic res_bit;

    assign accept   = in_valid && (state_q == IDLE);
    assign last_bit = (cnt_q == CW'(WIDTH-1));
    // Bits up to and including the first 1 pass through; everything above it is inverted.
    assign res_bit  = found_q ? ~sreg_q[0] : sreg_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            min_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            min_q   <= min_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_data[WIDTH-1] ? SHIFT : DONE;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        min_d   = min_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = in_data;
                    sign_d  = in_data[WIDTH-1];
                    min_d   = (in_data == MIN_VAL);
                    cnt_d   = '0;
                    found_d = 1'b0;
                    mag_d   = in_data[WIDTH-1] ? '0 : in_data;
                end
            end
            SHIFT: begin
                mag_d   = {res_bit, mag_q[WIDTH-1:1]};
                found_d = found_q | sreg_q[0];
                sreg_d  = sreg_q >> 1;
                cnt_d   = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    assign out_sign = sign_q;
    assign out_mag  = mag_q;
    assign out_min  = min_q;

endmodule

// File: tb/tb_twos_comp_to_signmag.sv
// Bench for twos_comp_to_signmag at WIDTH=4 and WIDTH=8 sharing one clock and reset.
module tb_twos_comp_to_signmag;

    typedef struct {
        logic       sign;
        logic [7:0] mag;
        logic       min;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid_4, in_ready_4, out_valid_4, out_ready_4, out_sign_4, out_min_4;
    logic [3:0] in_data_4, out_mag_4;
    logic       in_valid_8, in_ready_8, out_valid_8, out_ready_8, out_sign_8, out_min_8;
    logic [7:0] in_data_8, out_mag_8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb4[$];
    exp_t sb8[$];

    twos_comp_to_signmag #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_4), .in_ready(in_ready_4), .in_data(in_data_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .out_sign(out_sign_4), .out_mag(out_mag_4), .out_min(out_min_4)
    );

    twos_comp_to_signmag #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_data(in_data_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out_sign(out_sign_8), .out_mag(out_mag_8), .out_min(out_min_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model4(input logic [3:0] x);
        exp_t       e;
        logic [3:0] n;
        n      = 4'd0 - x;
        e.sign = x[3];
        e.mag  = {4'b0, (x[3] ? n : x)};
        e.min  = (x == 4'b1000);
        e.lat  = x[3] ? 5 : 1;
        return e;
    endfunction

    function automatic exp_t model8(input logic [7:0] x);
        exp_t       e;
        logic [7:0] n;
        n      = 8'd0 - x;
        e.sign = x[7];
        e.mag  = x[7] ? n : x;
        e.min  = (x == 8'h80);
        e.lat  = x[7] ? 9 : 1;
        return e;
    endfunction

    // Waits (bounded) for in_ready, presents one word for the accept edge, records its expected result.
    task automatic send4(input logic [3:0] d);
        int k = 0;
        while (!in_ready_4 && k < 40) begin
            @(posedge clk); #1; k++;
        end
        in_valid_4 = 1'b1;
        in_data_4  = d;
        @(posedge clk); #1;
        in_valid_4 = 1'b0;
        in_data_4  = 4'($urandom);
        sb4.push_back(model4(d));
    endtask

    task automatic send8(input logic [7:0] d);
        int k = 0;
        while (!in_ready_8 && k < 40) begin
            @(posedge clk); #1; k++;
        end
        in_valid_8 = 1'b1;
        in_data_8  = d;
        @(posedge clk); #1;
        in_valid_8 = 1'b0;
        in_data_8  = 8'($urandom);
        sb8.push_back(model8(d));
    endtask

    // Latency counts the accept edge as 1; gives up after 40 edges.
    task automatic await4(output int lat);
        lat = 1;
        while (!out_valid_4 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic await8(output int lat);
        lat = 1;
        while (!out_valid_8 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (in_ready_4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_4); end
        checks++; if (out_valid_4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_4); end
        checks++; if (out_sign_4 !== 1'b0) begin errors++; $display("FAIL reset_out_sign got %b want 0", out_sign_4); end
        checks++; if (out_mag_4 !== 4'b0000) begin errors++; $display("FAIL reset_out_mag got %b want 0000", out_mag_4); end
        checks++; if (out_min_4 !== 1'b0) begin errors++; $display("FAIL reset_out_min got %b want 0", out_min_4); end
        checks++; if (out_valid_8 !== 1'b0 || in_ready_8 !== 1'b1) begin
            errors++; $display("FAIL reset_w8 got valid=%b ready=%b want valid=0 ready=1", out_valid_8, in_ready_8);
        end
    endtask

    task automatic test_convert_w4;
        logic [3:0] tbl [8];
        tbl = '{4'b0101, 4'b0000, 4'b1101, 4'b1111, 4'b1010, 4'b1000, 4'b0111, 4'b1001};
        for (int i = 0; i < 14; i++) begin
            logic [3:0] d;
            int         lat;
            exp_t       e;
            d = (i < 8) ? tbl[i] : 4'($urandom);
            send4(d);
            await4(lat);
            e = sb4.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL w4_latency in=%b got %0d want %0d", d, lat, e.lat); end
            checks++; if (out_sign_4 !== e.sign) begin errors++; $display("FAIL w4_sign in=%b got %b want %b", d, out_sign_4, e.sign); end
            checks++; if (out_mag_4 !== e.mag[3:0]) begin errors++; $display("FAIL w4_mag in=%b got %b want %b", d, out_mag_4, e.mag[3:0]); end
            checks++; if (out_min_4 !== e.min) begin errors++; $display("FAIL w4_min in=%b got %b want %b", d, out_min_4, e.min); end
            @(posedge clk); #1;
            checks++; if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0) begin
                errors++; $display("FAIL w4_release in=%b got ready=%b valid=%b want 1 0", d, in_ready_4, out_valid_4);
            end
        end
    endtask

    task automatic test_convert_w8;
        logic [7:0] tbl [6];
        tbl = '{8'h80, 8'h7F, 8'hFF, 8'h81, 8'h00, 8'hC4};
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            int         lat;
            exp_t       e;
            d = (i < 6) ? tbl[i] : 8'($urandom);
            send8(d);
            await8(lat);
            e = sb8.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL w8_latency in=%h got %0d want %0d", d, lat, e.lat); end
            checks++; if (out_sign_8 !== e.sign || out_mag_8 !== e.mag || out_min_8 !== e.min) begin
                errors++;
                $display("FAIL w8_result in=%h got sign=%b mag=%h min=%b want sign=%b mag=%h min=%b",
                         d, out_sign_8, out_mag_8, out_min_8, e.sign, e.mag, e.min);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int   lat;
        exp_t e;
        out_ready_4 = 1'b0;
        send4(4'b1011);
        in_valid_4 = 1'b1;
        in_data_4  = 4'b0110;
        await4(lat);
        e = sb4.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, e.lat); end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid_4 !== 1'b1 || in_ready_4 !== 1'b0 || out_sign_4 !== e.sign ||
                out_mag_4 !== e.mag[3:0] || out_min_4 !== e.min) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b sign=%b mag=%b min=%b want 1 0 %b %b %b",
                         c, out_valid_4, in_ready_4, out_sign_4, out_mag_4, out_min_4, e.sign, e.mag[3:0], e.min);
            end
            @(posedge clk); #1;
        end
        out_ready_4 = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0) begin
            errors++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", in_ready_4, out_valid_4);
        end
        @(posedge clk); #1;
        in_valid_4 = 1'b0;
        checks++; if (out_valid_4 !== 1'b1 || out_sign_4 !== 1'b0 || out_mag_4 !== 4'b0110) begin
            errors++; $display("FAIL bp_next_word got valid=%b sign=%b mag=%b want 1 0 0110", out_valid_4, out_sign_4, out_mag_4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int   lat;
        exp_t e;
        send4(4'b1101);
        sb4.delete();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0 || out_sign_4 !== 1'b0 ||
            out_mag_4 !== 4'b0000 || out_min_4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_values got ready=%b valid=%b sign=%b mag=%b min=%b want 1 0 0 0000 0",
                     in_ready_4, out_valid_4, out_sign_4, out_mag_4, out_min_4);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checks++; if (out_valid_4 !== 1'b0) begin errors++; $display("FAIL mid_reset_stale cycle=%0d got valid=%b want 0", c, out_valid_4); end
            @(posedge clk); #1;
        end
        send4(4'b1110);
        await4(lat);
        e = sb4.pop_front();
        checks++; if (lat !== 5) begin errors++; $display("FAIL mid_reset_latency got %0d want 5", lat); end
        checks++; if (out_sign_4 !== 1'b1 || out_mag_4 !== 4'b0010 || out_mag_4 !== e.mag[3:0]) begin
            errors++; $display("FAIL mid_reset_result got sign=%b mag=%b want 1 0010", out_sign_4, out_mag_4);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_4  = 1'b0;
        in_data_4   = 4'b0;
        out_ready_4 = 1'b1;
        in_valid_8  = 1'b0;
        in_data_8   = 8'b0;
        out_ready_8 = 1'b1;
        test_reset;
        test_convert_w4;
        test_convert_w8;
        test_backpressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
